// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR width, FSM state type and step/seed helpers
//   lfsr_next : one Fibonacci step, taps 4,3,2,0 feeding bit 7, zero escapes to 8'h01
//   seed_fix  : coerces an all-zero seed to 8'h01 so the LFSR never starts locked
package lfsr_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    GRANT
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    if (q == '0) begin
      return LFSR_W'(1);
    end
    return {q[4] ^ q[3] ^ q[2] ^ q[0], q[7:1]};
  endfunction

  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/lfsr_share_ctrl_rr_pick.sv
// rtl/lfsr_share_ctrl_rr_pick.sv - combinational round-robin requester select
//   req_i [NREQ] : level requests
//   ptr_i [PW]   : highest-priority index, always < NREQ
//   win_o [PW]   : first set request at ptr, ptr+1, ... wrapping modulo NREQ
//   any_o        : at least one request is set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   win_o,
  output logic            any_o
);

  int idx;

  // Scan offsets from far to near so the nearest hit is the last one written.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (req_i[idx[PW-1:0]]) begin
        win_o = idx[PW-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// rtl/lfsr_share_ctrl.sv - shares one 8-bit LFSR among NREQ round-robin requesters
//   clk_i, rst_i       : clock, synchronous active-high reset
//   req_i [NREQ]       : level requests, held until the matching grant
//   seed_load_i        : loads seed_data_i (zero coerced to 8'h01), aborts any grant in flight
//   seed_data_i [8]    : seed value
//   run_i              : free-run enable, honoured only when idle with no requests
//   gnt_o [NREQ]       : one-hot, one-cycle grant
//   rnd_data_o [8]     : value handed out, valid while gnt_o is non-zero
//   lfsr_o [8]         : live LFSR register for the display decoders
//   busy_o             : sequencer is in STEP or GRANT
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int                NREQ = 4,
  parameter logic [LFSR_W-1:0] SEED = 8'h01,
  parameter int                DIV  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_data_i,
  input  logic              run_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [LFSR_W-1:0] rnd_data_o,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic              busy_o
);

  localparam int PW = $clog2(NREQ);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [LFSR_W-1:0] SEED_V = seed_fix(SEED);

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     ptr_d;
  logic [PW-1:0]     win_q;
  logic [DW-1:0]     divcnt_q;
  logic [DW-1:0]     divcnt_d;
  logic [NREQ-1:0]   gnt_q;
  logic [LFSR_W-1:0] rnd_q;
  logic [PW-1:0]     pick_win;
  logic              pick_any;
  logic              div_wrap;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .any_o (pick_any)
  );

  assign lfsr_d   = lfsr_next(lfsr_q);
  assign div_wrap = (divcnt_q == DW'(DIV - 1));
  assign divcnt_d = div_wrap ? '0 : divcnt_q + 1'b1;
  // Wrap at NREQ rather than at 2^PW so non-power-of-two NREQ stays in range.
  assign ptr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_V;
      ptr_q    <= '0;
      win_q    <= '0;
      divcnt_q <= '0;
      gnt_q    <= '0;
      rnd_q    <= '0;
    end else if (seed_load_i) begin
      // Kills any STEP/GRANT in flight; ptr is kept so fairness is preserved.
      state_q  <= IDLE;
      lfsr_q   <= seed_fix(seed_data_i);
      divcnt_q <= '0;
      gnt_q    <= '0;
      rnd_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          gnt_q <= '0;
          rnd_q <= '0;
          if (pick_any) begin
            win_q   <= pick_win;
            state_q <= STEP;
          end else if (run_i) begin
            divcnt_q <= divcnt_d;
            if (div_wrap) begin
              lfsr_q <= lfsr_d;
            end
          end
        end
        STEP: begin
          // Grant and data are registered here so both appear together in GRANT.
          lfsr_q  <= lfsr_d;
          rnd_q   <= lfsr_d;
          gnt_q   <= {{(NREQ - 1){1'b0}}, 1'b1} << win_q;
          state_q <= GRANT;
        end
        GRANT: begin
          gnt_q   <= '0;
          rnd_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign rnd_data_o = rnd_q;
  assign lfsr_o     = lfsr_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// tb/tb_lfsr_share_ctrl.sv - directed and randomized bench for lfsr_share_ctrl
module tb_lfsr_share_ctrl;

  localparam int NREQ = 4;
  localparam int SEED = 1;
  localparam int DIV  = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       seed_load;
  logic [7:0] seed_data;
  logic       run;
  logic [3:0] gnt;
  logic [7:0] rnd_data;
  logic [7:0] lfsr;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int m_lfsr  = 1;
  int m_phase = 0;
  int m_ptr   = 0;
  int m_win   = 0;
  int m_div   = 0;
  int m_gnt   = 0;
  int m_rnd   = 0;

  logic [7:0] rr_tbl [5];
  logic [7:0] v;
  int         changes;

  lfsr_share_ctrl #(
    .NREQ (NREQ),
    .SEED (8'(SEED)),
    .DIV  (DIV)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .seed_load_i (seed_load),
    .seed_data_i (seed_data),
    .run_i       (run),
    .gnt_o       (gnt),
    .rnd_data_o  (rnd_data),
    .lfsr_o      (lfsr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_next(input int q);
    int fb;
    if (q == 0) return 1;
    fb = ((q >> 4) ^ (q >> 3) ^ (q >> 2) ^ q) & 1;
    return (q >> 1) | (fb << 7);
  endfunction

  function automatic int ref_fix(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int ref_pick(input int r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (((r >> ((p + k) % NREQ)) & 1) != 0) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_lfsr = ref_fix(SEED); m_phase = 0; m_ptr = 0; m_div = 0; m_gnt = 0; m_rnd = 0;
    end else if (seed_load) begin
      m_lfsr = ref_fix(int'(seed_data)); m_phase = 0; m_div = 0; m_gnt = 0; m_rnd = 0;
    end else if (m_phase == 0) begin
      m_gnt = 0; m_rnd = 0;
      if (req != 0) begin
        m_win   = ref_pick(int'(req), m_ptr);
        m_phase = 1;
      end else if (run) begin
        if (m_div == DIV - 1) begin
          m_lfsr = ref_next(m_lfsr);
          m_div  = 0;
        end else begin
          m_div = m_div + 1;
        end
      end
    end else if (m_phase == 1) begin
      m_lfsr  = ref_next(m_lfsr);
      m_gnt   = 1 << m_win;
      m_rnd   = m_lfsr;
      m_phase = 2;
    end else begin
      m_gnt = 0; m_rnd = 0;
      m_ptr = (m_win + 1) % NREQ;
      m_phase = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("rnd_data", 32'(rnd_data), 32'(m_rnd));
    chk("lfsr_q", 32'(lfsr), 32'(m_lfsr));
    chk("busy", 32'(busy), 32'(m_phase != 0));
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; seed_load = 1'b0; seed_data = '0; run = 1'b0;
    rr_tbl[0] = 8'h80; rr_tbl[1] = 8'h40; rr_tbl[2] = 8'h20; rr_tbl[3] = 8'h10; rr_tbl[4] = 8'h88;

    // Reset
    cycle(); cycle();
    chk("t1_lfsr", 32'(lfsr), 32'h01);
    chk("t1_gnt", 32'(gnt), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single request
    req = 4'b0001;
    cycle();
    chk("t2_busy_c1", 32'(busy), 32'h1);
    chk("t2_gnt_c1", 32'(gnt), 32'h0);
    cycle();
    chk("t2_gnt", 32'(gnt), 32'h1);
    chk("t2_rnd", 32'(rnd_data), 32'h80);
    chk("t2_busy_c2", 32'(busy), 32'h1);
    req = '0;
    cycle();

    // Round robin from a fresh reset
    rst = 1'b1; cycle(); rst = 1'b0;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cycle(); cycle();
      chk("t3_gnt", 32'(gnt), 32'(1 << (k % 4)));
      chk("t3_rnd", 32'(rnd_data), 32'(rr_tbl[k]));
      cycle();
    end
    req = '0;

    // Seed load, zero coercion and abort during STEP
    seed_load = 1'b1; seed_data = 8'h00;
    cycle();
    chk("t4_zero_seed", 32'(lfsr), 32'h01);
    seed_load = 1'b0;
    req = 4'hF;
    cycle();
    seed_load = 1'b1; seed_data = 8'h5A;
    cycle();
    chk("t4_abort_gnt", 32'(gnt), 32'h0);
    chk("t4_abort_lfsr", 32'(lfsr), 32'h5A);
    seed_load = 1'b0;
    cycle(); cycle();
    chk("t4_ptr_gnt", 32'(gnt), 32'h2);
    chk("t4_ptr_rnd", 32'(rnd_data), 32'h2D);
    req = '0;
    cycle();

    // Free run every DIV cycles, then a request mid-count
    run = 1'b1;
    changes = 0;
    for (int k = 0; k < 12; k++) begin
      v = lfsr;
      cycle();
      if (lfsr != v) changes++;
    end
    chk("t5_steps", 32'(changes), 32'(12 / DIV));
    cycle(); cycle();
    req = 4'b0100;
    cycle(); cycle();
    chk("t5_gnt", 32'(gnt), 32'h4);
    v = lfsr;
    req = '0;
    cycle(); cycle();
    chk("t5_hold", 32'(lfsr), 32'(v));
    cycle();
    chk("t5_resume", 32'(lfsr), 32'(ref_next(int'(v))));
    run = 1'b0;

    // Reset during GRANT
    req = 4'b0001;
    cycle(); cycle();
    chk("t6_gnt_pre", 32'(gnt), 32'h1);
    rst = 1'b1; req = '0;
    cycle();
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_lfsr", 32'(lfsr), 32'h01);
    rst = 1'b0;
    req = 4'hF;
    cycle(); cycle();
    chk("t6_ptr0", 32'(gnt), 32'h1);
    req = '0;
    cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 63) == 0);
      seed_load = ($urandom_range(0, 15) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run       = 1'($urandom);
      req       = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
